// File: rtl/bit_pattern_detector.sv
// Serial bit-pattern detector: shifts accepted bits into a sliding window and
// pulses match on each occurrence of PATTERN, keeping a saturating match count.
module bit_pattern_detector #(
   parameter int                     PATTERN_LEN = 4,
   parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
   parameter bit                     OVERLAP     = 1'b1,
   parameter int                     CNT_W       = 8
) (
   input  logic                   clk,
   input  logic                   R,
   input  logic                   D,
   input  logic                   en,
   output logic [PATTERN_LEN-1:0] Q,
   output logic                   match,
   output logic [CNT_W-1:0]       match_cnt,
   output logic                   sat
);

   localparam int               FILL_W   = $clog2(PATTERN_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_LEN);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_MAX - 1'b1;

   logic [FILL_W-1:0]      fill;
   logic [FILL_W-1:0]      nf;
   logic [PATTERN_LEN-1:0] nq;
   logic                   hit;

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      nq  = {Q[PATTERN_LEN-2:0], D};
      nf  = (fill == FILL_FULL) ? fill : fill + 1'b1;
      hit = (nf == FILL_FULL) && (nq == PATTERN);
   end

   // The fill gate keeps reset-zero window contents from forming a false match.
   // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (R) begin
         Q         <= '0;
         fill      <= '0;
         match     <= 1'b0;
         match_cnt <= '0;
         sat       <= 1'b0;
      end else if (en) begin
         Q     <= nq;
         match <= hit;
         fill  <= (hit && !OVERLAP) ? '0 : nf;
         if (hit && (match_cnt != CNT_MAX)) begin
            match_cnt <= match_cnt + 1'b1;
            if (match_cnt == CNT_LAST)
               sat <= 1'b1;
         end
      end else begin
         match <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bit_pattern_detector.sv
// Directed bench for bit_pattern_detector: five parameterisations share one
// stimulus stream, each scenario checking the instance it targets.
module tb_bit_pattern_detector;

   logic clk = 1'b0;
   logic r   = 1'b0;
   logic d   = 1'b0;
   logic en  = 1'b0;

   int total = 0;
   int fails = 0;

   logic [3:0] q0, q1, q2, q3, q4;
   logic       m0, m1, m2, m3, m4;
   logic [7:0] c0, c1, c2, c3;
   logic [1:0] c4;
   logic       s0, s1, s2, s3, s4;

   always #5 clk = ~clk;

   bit_pattern_detector u0 (.clk(clk), .R(r), .D(d), .en(en), .Q(q0), .match(m0), .match_cnt(c0), .sat(s0));

   bit_pattern_detector #(.OVERLAP(1'b0)) u1 (
      .clk(clk), .R(r), .D(d), .en(en), .Q(q1), .match(m1), .match_cnt(c1), .sat(s1));

   bit_pattern_detector #(.PATTERN(4'b0000), .OVERLAP(1'b1)) u2 (
      .clk(clk), .R(r), .D(d), .en(en), .Q(q2), .match(m2), .match_cnt(c2), .sat(s2));

   bit_pattern_detector #(.PATTERN(4'b0000), .OVERLAP(1'b0)) u3 (
      .clk(clk), .R(r), .D(d), .en(en), .Q(q3), .match(m3), .match_cnt(c3), .sat(s3));

   bit_pattern_detector #(.CNT_W(2), .OVERLAP(1'b1)) u4 (
      .clk(clk), .R(r), .D(d), .en(en), .Q(q4), .match(m4), .match_cnt(c4), .sat(s4));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply inputs, take one rising edge, then settle so outputs are sampled off-edge.
   task automatic step(input logic rv, input logic dv, input logic ev);
      r  = rv;
      d  = dv;
      en = ev;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [6:0]  s1_bits, s1_m0, s1_m1;
      logic [4:0]  s2_m2, s2_m3;
      logic [3:0]  s3_bits;
      logic [12:0] s5_bits, s5_m;
      logic [1:0]  s5_cnt [13];
      logic        s5_sat [13];

      #1;
      // Reset state
      step(1'b1, 1'b1, 1'b1);
      check("reset_q", 32'(q0), 32'h0);
      check("reset_match", 32'(m0), 32'h0);
      check("reset_cnt", 32'(c0), 32'h0);
      check("reset_sat", 32'(s0), 32'h0);

      // Scenario 1: 1,0,1,1,0,1,1 overlap vs non-overlap
      s1_bits = 7'b1011011;
      s1_m0   = 7'b0001001;
      s1_m1   = 7'b0001000;
      for (int i = 0; i < 7; i++) begin
         step(1'b0, s1_bits[6-i], 1'b1);
         check($sformatf("s1_ov_match_bit%0d", i + 1), 32'(m0), 32'(s1_m0[6-i]));
         check($sformatf("s1_nov_match_bit%0d", i + 1), 32'(m1), 32'(s1_m1[6-i]));
      end
      check("s1_ov_cnt", 32'(c0), 32'd2);
      check("s1_ov_q", 32'(q0), 32'hb);
      check("s1_nov_cnt", 32'(c1), 32'd1);
      check("s1_nov_fill", 32'(u1.fill), 32'd3);
      check("s1_nov_q", 32'(q1), 32'hb);

      // Scenario 2: all-zero pattern needs a full window after reset
      step(1'b1, 1'b0, 1'b0);
      s2_m2 = 5'b00011;
      s2_m3 = 5'b00010;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b1);
         check($sformatf("s2_ov_match_bit%0d", i + 1), 32'(m2), 32'(s2_m2[4-i]));
         check($sformatf("s2_nov_match_bit%0d", i + 1), 32'(m3), 32'(s2_m3[4-i]));
      end
      check("s2_ov_cnt", 32'(c2), 32'd2);
      check("s2_nov_cnt", 32'(c3), 32'd1);

      // Scenario 3: en gaps with random D
      step(1'b1, 1'b0, 1'b0);
      s3_bits = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, s3_bits[3-i], 1'b1);
         check($sformatf("s3_match_bit%0d", i + 1), 32'(m0), (i == 3) ? 32'd1 : 32'd0);
         for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'($urandom_range(1, 0)), 1'b0);
            check($sformatf("s3_gap_b%0d_g%0d", i + 1, g), 32'(m0), 32'd0);
         end
      end
      check("s3_cnt", 32'(c0), 32'd1);
      check("s3_q", 32'(q0), 32'hb);

      // Scenario 4: reset mid-pattern, reset wins over completing bit
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      check("s4_rst_match", 32'(m0), 32'd0);
      check("s4_rst_cnt", 32'(c0), 32'd0);
      check("s4_rst_q", 32'(q0), 32'h0);
      step(1'b0, 1'b1, 1'b1);
      check("s4_fresh1", 32'(m0), 32'd0);
      step(1'b0, 1'b0, 1'b1);
      check("s4_fresh2", 32'(m0), 32'd0);
      step(1'b0, 1'b1, 1'b1);
      check("s4_fresh3", 32'(m0), 32'd0);
      step(1'b0, 1'b1, 1'b1);
      check("s4_fresh4", 32'(m0), 32'd1);
      check("s4_cnt", 32'(c0), 32'd1);

      // Scenario 5: 2-bit counter saturation
      step(1'b1, 1'b0, 1'b0);
      s5_bits = 13'b1011011011011;
      s5_m    = 13'b0001001001001;
      s5_cnt  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
      s5_sat  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 13; i++) begin
         step(1'b0, s5_bits[12-i], 1'b1);
         check($sformatf("s5_match_bit%0d", i + 1), 32'(m4), 32'(s5_m[12-i]));
         check($sformatf("s5_cnt_bit%0d", i + 1), 32'(c4), 32'(s5_cnt[i]));
         check($sformatf("s5_sat_bit%0d", i + 1), 32'(s4), 32'(s5_sat[i]));
      end
      step(1'b0, 1'b1, 1'b0);
      check("s5_hold_match", 32'(m4), 32'd0);
      check("s5_hold_cnt", 32'(c4), 32'd3);
      check("s5_hold_sat", 32'(s4), 32'd1);
      step(1'b1, 1'b1, 1'b1);
      check("s5_rst_cnt", 32'(c4), 32'd0);
      check("s5_rst_sat", 32'(s4), 32'd0);
      check("s5_rst_match", 32'(m4), 32'd0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
